sap_mem_arbiter: RTL and testbench
==================================

# sap_mem_arbiter

Two-port arbiter sharing the single 16×8 synchronous RAM of the SAP-1 between the CPU datapath (fetch/operand reads driven by the microsequencer) and the program loader (debug/boot port that writes programs into RAM). It serialises accesses through a fixed three-cycle access FSM, returns a one-cycle acknowledge to the winning requester, and gives the loader a lock that excludes the CPU during program download. It sits between both requesters and the RAM macro.

## Interface
- AW, 4, address width
- DW, 8, data width
- CW, 8, width of contention counter
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  DW  read data, valid while cpu_ack high
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata  same as cpu_* for the loader port
- ldr_lock  in  1  while high the CPU is never granted
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable (only with mem_en)
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid cycle after mem_en sampled
- owner  out  1  0 = CPU, 1 = loader; current/last grantee
- busy  out  1  high in ACCESS and RESP
- conflict_cnt  out  CW  saturating count of contended arbitrations

## Operation
- FSM states: IDLE, ACCESS, RESP. IDLE→ACCESS when an eligible request exists; ACCESS→RESP always; RESP→IDLE always.
- Eligible: ldr_req; cpu_req && !ldr_lock.
- Arbitration in IDLE only: winner, its we/addr/wdata latched into registers at the IDLE→ACCESS edge; owner updated at same edge.
- Contention = both eligible in IDLE; conflict_cnt increments by 1 on that edge, saturates at 2^CW−1, never wraps.
- ACCESS: mem_en=1, mem_we/mem_addr/mem_wdata from latched registers.
- RESP: owner's ack=1; other port's ack=0. x_rdata is a combinational pass-through of mem_rdata (both ports); meaningful only with x_ack on a read.
- Transaction always completes once in ACCESS: requester dropping req, or ldr_lock rising, mid-transaction does not abort it; ack is still issued.
- Requester must deassert req in the cycle after ack unless it wants another access; a req still high in IDLE is a new request.
- Reset values: state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ack=0, ldr_ack=0, owner=0, busy=0, conflict_cnt=0, latched registers 0.
- Reset mid-transaction: next edge returns to IDLE; no ack issued; mem_en/mem_we low from that edge.

## Timing
- req sampled at edge N (IDLE) → mem_en high cycle N+1 → ack high cycle N+2 → IDLE cycle N+3.
- Throughput: one access per 3 cycles; continuous req from one port yields ack every 3rd cycle.
- All outputs except x_rdata are registered.
- ldr_lock is evaluated only in IDLE.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on contention grant the port that did not own the previous transaction (owner after reset = 0, so first contention goes to loader).
- Undefined: fixed priority, loader always wins contention.
- ldr_lock behaviour identical in both builds.

## Test plan
- Single CPU read addr 4'h3, RAM holds 8'hA5 → mem_en cycle N+1 with mem_addr=3, mem_we=0; cpu_ack cycle N+2 with cpu_rdata=8'hA5; busy high 2 cycles.
- Loader write 8'h1E to addr 4'hF then CPU read 4'hF → mem_we=1 in first ACCESS; cpu_rdata=8'h1E at cpu_ack.
- Both req held continuously 12 cycles → RR build: owners alternate 1,0,1,0; fixed build: 4 loader acks, 0 CPU; conflict_cnt=4.
- ldr_lock=1, cpu_req=1, ldr_req=0 for 10 cycles → no mem_en, cpu_ack never; drop lock → cpu_ack 2 cycles after next IDLE sample.
- rst asserted in ACCESS cycle → no ack, next cycle mem_en=0, all outputs at reset values, conflict_cnt=0.
- Force 300 contended arbitrations with CW=8 → conflict_cnt stops at 255.

Source files
------------

// File: rtl/sap_mem_arbiter.sv
// rtl/sap_mem_arbiter.sv - SAP-1 RAM arbiter (CPU vs loader), three-cycle access FSM.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of loader priority.
module sap_mem_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    input  logic          ldr_lock,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy,
    output logic [CW-1:0] conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, next_state;
    logic   cpu_elig, ldr_elig;
    logic   grant, grant_ldr, contend;

    assign cpu_elig = cpu_req && !ldr_lock;
    assign ldr_elig = ldr_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_ldr  = 1'b0;
        contend    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_elig || ldr_elig) begin
                    next_state = ACCESS;
                    grant      = 1'b1;
                    contend    = cpu_elig && ldr_elig;
                    if (contend) begin
`ifdef ARB_ROUND_ROBIN_EN
                        grant_ldr = !owner;
`else
                        grant_ldr = 1'b1;
`endif
                    end else begin
                        grant_ldr = ldr_elig;
                    end
                end
            end
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // mem_addr/mem_wdata double as the latched request registers; mem_we is only
    // ever set on a grant so it can never be high without mem_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_ack      <= 1'b0;
            ldr_ack      <= 1'b0;
            owner        <= 1'b0;
            busy         <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            mem_en  <= grant;
            busy    <= (next_state != IDLE);
            cpu_ack <= (state == ACCESS) && !owner;
            ldr_ack <= (state == ACCESS) && owner;
            mem_we  <= grant ? (grant_ldr ? ldr_we : cpu_we) : 1'b0;
            if (grant) begin
                owner     <= grant_ldr;
                mem_addr  <= grant_ldr ? ldr_addr : cpu_addr;
                mem_wdata <= grant_ldr ? ldr_wdata : cpu_wdata;
            end
            if (contend && (conflict_cnt != {CW{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CW'(1);
            end
        end
    end

    assign cpu_rdata = mem_rdata;
    assign ldr_rdata = mem_rdata;

endmodule

// File: tb/tb_sap_mem_arbiter.sv
// tb/tb_sap_mem_arbiter.sv - directed self-checking bench for sap_mem_arbiter.
module tb_sap_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
    logic [3:0] cpu_addr, ldr_addr;
    logic [7:0] cpu_wdata, ldr_wdata;
    logic       cpu_ack, ldr_ack;
    logic [7:0] cpu_rdata, ldr_rdata;
    logic       mem_en, mem_we, owner, busy;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [7:0] conflict_cnt;
    logic [7:0] ram [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sap_mem_arbiter #(.AW(4), .DW(8), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .ldr_lock(ldr_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy), .conflict_cnt(conflict_cnt)
    );

    // 16x8 synchronous RAM model; reset loads 8'hA5 at address 3.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ram[i] <= (i == 3) ? 8'hA5 : 8'h00;
            mem_rdata <= 8'h00;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int         n_cpu, n_ldr, n_ack, n_en;
    logic [3:0] seq;

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_lock = 0;
        step(); step();
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_acks", {cpu_ack, ldr_ack}, 0);
        check("rst_owner", owner, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", conflict_cnt, 0);
        rst = 1'b0;
        step();

        // single CPU read of address 3
        cpu_req = 1; cpu_we = 0; cpu_addr = 4'h3;
        step();
        check("rd_mem_en", mem_en, 1);
        check("rd_mem_addr", mem_addr, 4'h3);
        check("rd_mem_we", mem_we, 0);
        check("rd_busy1", busy, 1);
        check("rd_ack_early", cpu_ack, 0);
        step();
        check("rd_ack", cpu_ack, 1);
        check("rd_data", cpu_rdata, 8'hA5);
        check("rd_busy2", busy, 1);
        check("rd_mem_en_off", mem_en, 0);
        cpu_req = 0;
        step();
        check("rd_idle_busy", busy, 0);
        check("rd_idle_ack", cpu_ack, 0);

        // loader write 1E to F, then CPU read back
        ldr_req = 1; ldr_we = 1; ldr_addr = 4'hF; ldr_wdata = 8'h1E;
        step();
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 4'hF);
        check("wr_mem_wdata", mem_wdata, 8'h1E);
        check("wr_owner", owner, 1);
        step();
        check("wr_ldr_ack", ldr_ack, 1);
        check("wr_cpu_ack", cpu_ack, 0);
        ldr_req = 0; ldr_we = 0;
        step();
        cpu_req = 1; cpu_addr = 4'hF;
        step();
        check("rb_owner", owner, 0);
        step();
        check("rb_ack", cpu_ack, 1);
        check("rb_data", cpu_rdata, 8'h1E);
        cpu_req = 0;
        step();

        // both ports hold req for 12 cycles
        cpu_req = 1; ldr_req = 1; cpu_addr = 4'h0; ldr_addr = 4'h1;
        n_cpu = 0; n_ldr = 0; n_ack = 0; seq = 4'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (cpu_ack) n_cpu++;
            if (ldr_ack) n_ldr++;
            if ((cpu_ack || ldr_ack) && n_ack < 4) begin
                seq = {seq[2:0], ldr_ack};
                n_ack++;
            end
        end
        cpu_req = 0; ldr_req = 0;
`ifdef ARB_ROUND_ROBIN_EN
        check("con_ldr_acks", n_ldr, 2);
        check("con_cpu_acks", n_cpu, 2);
        check("con_owner_seq", seq, 4'b1010);
`else
        check("con_ldr_acks", n_ldr, 4);
        check("con_cpu_acks", n_cpu, 0);
        check("con_owner_seq", seq, 4'b1111);
`endif
        check("con_cnt", conflict_cnt, 4);
        step();

        // lock excludes the CPU
        ldr_lock = 1; cpu_req = 1; cpu_addr = 4'h3;
        n_en = 0; n_cpu = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (mem_en) n_en++;
            if (cpu_ack) n_cpu++;
        end
        check("lock_mem_en", n_en, 0);
        check("lock_cpu_ack", n_cpu, 0);
        check("lock_cnt", conflict_cnt, 4);
        ldr_lock = 0;
        step();
        check("unlock_mem_en", mem_en, 1);
        step();
        check("unlock_ack", cpu_ack, 1);
        check("unlock_data", cpu_rdata, 8'hA5);
        cpu_req = 0;
        step();

        // reset during ACCESS
        cpu_req = 1; cpu_we = 1; cpu_addr = 4'h5; cpu_wdata = 8'h77;
        step();
        check("mid_access", mem_en, 1);
        rst = 1;
        step();
        check("mid_mem_en", mem_en, 0);
        check("mid_mem_we", mem_we, 0);
        check("mid_addr", mem_addr, 0);
        check("mid_wdata", mem_wdata, 0);
        check("mid_busy", busy, 0);
        check("mid_acks", {cpu_ack, ldr_ack}, 0);
        check("mid_cnt", conflict_cnt, 0);
        rst = 0; cpu_req = 0; cpu_we = 0;
        step();
        check("mid_no_ack", cpu_ack, 0);
        step();

        // counter saturation: 300 contended arbitrations
        cpu_req = 1; ldr_req = 1; ldr_we = 0;
        for (int c = 0; c < 300 * 3; c++) begin
            step();
            if (c == 100 * 3 - 1) check("sat_cnt_100", conflict_cnt, 100);
            if (c == 255 * 3 - 1) check("sat_cnt_255", conflict_cnt, 255);
        end
        cpu_req = 0; ldr_req = 0;
        step();
        check("sat_cnt_end", conflict_cnt, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
